rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-requester round-robin arbiter that shares one processor resource (the common data bus / single register-file write port) between up to eight masters. It issues a registered one-hot grant plus its 3-bit index, holds ownership until the owner releases, and rotates priority so no requester starves. It sits between the requesting units and the bus select/enable logic of the processor model.

## Interface
- MAX_HOLD, 16, maximum consecutive grant cycles per owner before forced release (legal 2..255; used only with timeout enabled)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request vector, bit i = requester i; level, held until served
- done  in  1  owner release strobe; sampled only while a grant is active
- gnt  out  8  one-hot grant, registered; all-zero when idle
- gnt_idx  out  3  binary index of current owner; 0 when idle
- gnt_valid  out  1  high whenever gnt is non-zero
- timeout  out  1  one-cycle pulse on forced release; constant 0 when timeout compiled out

## Operation
- States: IDLE, BUSY. Reset -> IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold count=0.
- Reset is asynchronous on assertion; all state and outputs return to reset values immediately, including mid-grant.
- Priority search: scan from ptr upward, wrap 7->0; first set req bit wins. ptr = (winner+1) mod 8, updated on every new grant.
- IDLE: if req!=0, go BUSY, grant winner. If req==0, stay IDLE; done ignored.
- BUSY release condition: done=1, or req[gnt_idx]=0, or (timeout enabled) hold count reached MAX_HOLD-1.
- On release: if any other req bit (or the same one, if it is the only one) is set, grant new winner on the same edge (zero dead cycles); else return to IDLE with gnt=0.
- Because ptr already points past the releasing owner, the releasing owner is lowest priority on handover; it regains the bus only if no other bit is set.
- Simultaneous done and req change: done takes effect; new request bits sampled that same edge are eligible.
- gnt is always one-hot or zero; gnt_idx and gnt change together; gnt_valid = |gnt.
- Hold count resets to 0 on every new grant (including same-owner regrant), increments each BUSY cycle, saturates.

## Timing
- Grant latency: req sampled at edge N -> gnt visible after edge N (one cycle after req rises).
- Release latency: done sampled at edge N -> gnt drops or moves to next owner after edge N.
- Owner holds for at least one full cycle.
- timeout high exactly the cycle following the forced-release edge, concurrent with the new grant.
- No combinational path from inputs to outputs.

## Configuration
- ARB_TIMEOUT_EN defined: hold counter and forced release active; timeout pulses as specified.
- ARB_TIMEOUT_EN undefined: no counter logic; owner holds until done or own req drop; timeout tied 0; MAX_HOLD unused.

## Structure
- Package arb_pkg: N_REQ=8, IDX_W=3, state enum (IDLE, BUSY), counter width function for MAX_HOLD.
- One sub-module: rr_pick8 — combinational rotating priority picker (inputs req, ptr; outputs found, idx). Top module holds FSM, ptr, counter, output registers; one-hot gnt generated from registered idx.

## Test plan
- Reset mid-grant: owner 5 granted, drop rst_n -> gnt=0, gnt_idx=0, gnt_valid=0 immediately; after release, req=8'h20 -> gnt=8'h20 one cycle later.
- Single request: req=8'h04 from idle -> gnt=8'h04, gnt_idx=2 next cycle; done pulse -> gnt=0 next cycle.
- Rotation: req=8'hFF held, done every cycle -> gnt_idx sequence 0,1,2,...,7,0 with no idle cycles.
- Wrap and fairness: ptr=7 after owner 6, req=8'h41 -> owner 0 not 6; owner 6 resumes only after 0 releases.
- Owner drop: owner 3, req[3] falls with req=8'h88 -> next edge gnt=8'h80, gnt_idx=7.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h03, no done -> owner 0 for 4 cycles, timeout pulse, owner 1 granted same cycle; without macro owner 0 holds indefinitely, timeout=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-requester round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Smallest width whose range covers 0 .. max_hold-1.
  function automatic int cnt_width(input int max_hold);
    int w;
    w = 8;
    for (int b = 8; b >= 1; b--) begin
      if ((32'sd1 << b) >= max_hold) begin
        w = b;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request at or above ptr, wrapping 7 -> 0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_k;

  // Scan from the farthest offset down so the nearest set bit to ptr is written last.
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    w_k   = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_k = ptr + IDX_W'(i);
      if (req[w_k]) begin
        found = 1'b1;
        idx   = w_k;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to enable the MAX_HOLD forced-release counter.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic             w_expired;
  logic             w_release;
  logic             w_new_grant;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(MAX_HOLD);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_expired = (r_state == BUSY) && (r_cnt == CNT_W'(MAX_HOLD - 1));

  // Hold counter restarts on every grant, including a same-owner regrant, and saturates.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_new_grant) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if ((r_state == BUSY) && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  assign w_release = done | ~req[r_idx] | w_expired;

  // Next-state: a release hands over on the same edge; ptr already sits past the old owner.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    w_new_grant   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_idx_nxt   = w_pick;
          w_ptr_nxt   = w_pick + 3'd1;
          w_new_grant = 1'b1;
        end else begin
          w_idx_nxt = 3'd0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_timeout_nxt = w_expired & ~done & req[r_idx];
          if (w_found) begin
            w_idx_nxt   = w_pick;
            w_ptr_nxt   = w_pick + 3'd1;
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 3'd0;
          end
        end else begin
          w_state_nxt = BUSY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= 3'd0;
      r_ptr     <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt       = (r_state == BUSY) ? (8'b0000_0001 << r_idx) : 8'h00;
  assign gnt_idx   = r_idx;
  assign gnt_valid = (r_state == BUSY);
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus queues expected outputs, a monitor compares.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         tag;
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
    total++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || timeout !== et) begin
      bad++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               nm, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
    end
  endtask

  // Drive inputs for one sampling edge and queue what must appear after it.
  task automatic step(input logic [7:0] r, input logic d, input logic [7:0] eg,
                      input logic [2:0] ei, input logic et, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    req  = r;
    done = d;
    e.tag = cyc + 1;
    e.g   = eg;
    e.i   = ei;
    e.v   = (eg != 8'h00);
    e.t   = et;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.tag < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", mon_e.nm, mon_e.tag, cyc);
      end else begin
        check(mon_e.nm, mon_e.g, mon_e.i, mon_e.v, mon_e.t);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle_no_req");

    // Rotation with every requester asserted and done every cycle.
    step(8'hFF, 1'b0, 8'h01, 3'd0, 1'b0, "rot_0");
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF, 1'b1, 8'(8'h01 << (k % 8)), 3'(k % 8), 1'b0, "rot_step");
    end
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "rot_idle");

    // Single request (ptr=1).
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "single_grant");
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b0, "single_hold");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "single_done");

    // Owner drop (ptr=3).
    step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0, "drop_own3");
    step(8'h88, 1'b0, 8'h08, 3'd3, 1'b0, "drop_hold3");
    step(8'h80, 1'b0, 8'h80, 3'd7, 1'b0, "drop_to7");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "drop_idle");

    // Wrap and fairness (ptr=0).
    step(8'h40, 1'b0, 8'h40, 3'd6, 1'b0, "wrap_own6");
    step(8'h41, 1'b1, 8'h01, 3'd0, 1'b0, "wrap_to0");
    step(8'h41, 1'b0, 8'h01, 3'd0, 1'b0, "wrap_hold0");
    step(8'h41, 1'b1, 8'h40, 3'd6, 1'b0, "wrap_back6");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "wrap_idle");

    // Same owner regrant when it is the only requester (ptr=7).
    step(8'h40, 1'b0, 8'h40, 3'd6, 1'b0, "same_own6");
    step(8'h40, 1'b1, 8'h40, 3'd6, 1'b0, "same_regrant6");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "same_idle");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "idle_done_ignored");

    // Hold limit (ptr=7, MAX_HOLD=4).
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      step(8'h03, 1'b0, 8'h01, 3'd0, 1'b0, "to_own0");
    end
    step(8'h03, 1'b0, 8'h02, 3'd1, 1'b1, "to_forced");
    step(8'h03, 1'b0, 8'h02, 3'd1, 1'b0, "to_own1");
`else
    for (int k = 0; k < 6; k++) begin
      step(8'h03, 1'b0, 8'h01, 3'd0, 1'b0, "to_hold0");
    end
`endif
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "to_idle");

    // Reset in the middle of a grant.
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0, "pre_rst_own5");
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0, "pre_rst_hold5");
    repeat (3) @(negedge clk);
    #1;
    check("mid_grant", 8'h20, 3'd5, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0, "post_rst_own5");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "post_rst_idle");

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
